clpl_slice_sequencer: RTL and testbench
=======================================

Name: clpl_slice_sequencer

Overview:
- Sequential front/back end for the 5-bit carry-lookahead PLA stage (inputs x00..x10, outputs z0..z4).
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Each cycle it drives one 5-bit slice's generate/propagate terms into the PLA, captures the PLA carries, and forms that slice's sum bits.
- Slices are processed LSB-first and chained through a registered slice carry; the result leaves on a valid/ready handshake.

Parameters:
- WIDTH, 20, operand width in bits; must be a nonzero multiple of 5.
- NSLICE, WIDTH/5, derived slice count; not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offer.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  A+B+cin, low WIDTH bits.
- cout  output  1  carry out of the MSB.
- pla_x  output  11  to PLA inputs; pla_x[k] drives x(k), k=00..10.
- pla_z  input  5  from PLA outputs; pla_z[k] is z(k).

Behaviour:
- Reset is synchronous, active-high. On rst=1:
  - state = IDLE, slice index = 0, carry register = 0.
  - out_valid = 0, sum = 0, cout = 0, in_ready = 1 from the following cycle.
  - rst overrides every other input in the same cycle.
  - Reset during RUN or DONE aborts the operation; no result is ever presented for it.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready: latch a, b and cin; carry register = cin; index = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Slice s covers operand bits 5s..5s+4. Per bit i: g = a&b, p = a^b.
  - pla_x is combinational from the latched operands, the index and the carry register:
    - x00 = carry register.
    - bit0: x02 = g0, x04 = p0.
    - bit1: x03 = g1, x05 = p1.
    - bit2: x01 = g2, x06 = p2.
    - bit3: x07 = g3, x08 = p3.
    - bit4: x10 = g4, x09 = p4.
  - PLA carries are c1 = z2, c2 = z1, c3 = z0, c4 = z4, c5 = z3.
  - On each RUN edge:
    - sum[5s+j] <= p_j ^ c_j, with c0 = carry register.
    - carry register <= c5.
    - index increments.
  - After the edge that processes slice NSLICE-1: cout <= c5 and the state moves to DONE.
- DONE:
  - out_valid = 1; sum and cout are held stable while out_ready = 0.
  - On out_ready = 1: go to IDLE, out_valid = 0 the next cycle.
  - in_ready stays 0 until back in IDLE.
- pla_x = 0 whenever the state is not RUN.
- Timing:
  - Operands accepted at edge T give out_valid = 1 after edge T+NSLICE.
  - Minimum issue interval is NSLICE+2 cycles.
- Sum wraps modulo 2^WIDTH; the carry out of the MSB is reported only on cout.
- sum keeps its previous value until overwritten slice by slice during the next RUN. It is valid only while out_valid = 1.
- The combinational path pla_x -> PLA -> pla_z must settle within one cycle. The block has no combinational path from pla_z to any output port.

Optional Feature:
- Macro CLPL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf is registered alongside cout and equals the carry into the MSB XOR cout, i.e. signed two's-complement overflow.
  - ovf is 0 on reset and valid/held under the same rules as cout.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic add, WIDTH=20: a=0x00001, b=0x00001, cin=0, accepted at edge T -> out_valid after edge T+4, sum=0x00002, cout=0.
- Full carry chain: a=0xFFFFF, b=0x00000, cin=1 -> sum=0x00000, cout=1. The carry register reads 1 after every RUN edge.
- PLA mapping in slice 0: a=0x0001F, b=0x00001, cin=0 -> pla_x has x02=1; x05=x06=x08=x09=1; x00=x01=x03=x04=x07=x10=0. Final sum=0x00020, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, sum and cout stable and in_ready=0. Raise out_ready -> in_ready=1 one cycle later.
- Reset mid-op: assert rst at the edge that would process slice 2 -> out_valid never rises, in_ready=1 next cycle, pla_x=0. A new op (a=3, b=4) returns sum=7.
- With CLPL_OVF_EN: a=0x7FFFF, b=0x00001 -> sum=0x80000, cout=0, ovf=1. a=0xFFFFF, b=0x00001 -> cout=1, ovf=0.

Source files
------------

// File: rtl/clpl_slice_sequencer_if.sv
// rtl/clpl_slice_sequencer_if.sv - operand/result handshake bundle for clpl_slice_sequencer
//
// Signals:
//   in_valid/in_ready   operand offer and acceptance
//   a, b, cin           WIDTH-bit operands and carry-in
//   out_valid/out_ready result offer and acceptance
//   sum, cout           WIDTH-bit result and carry out of the MSB
//   ovf                 signed overflow, present only when CLPL_OVF_EN is defined
// Modports: slave = the sequencer, master = the operand source / result sink.

interface clpl_slice_sequencer_if #(
    parameter int WIDTH = 20
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLPL_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CLPL_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CLPL_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/clpl_slice_sequencer.sv
// rtl/clpl_slice_sequencer.sv - slice-serial adder driving an external 5-bit carry-lookahead PLA
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   bus    clpl_slice_sequencer_if.slave: operand handshake (in_valid/in_ready/a/b/cin)
//          and result handshake (out_valid/out_ready/sum/cout[/ovf])
//   pla_x  11-bit drive into the PLA inputs x00..x10
//   pla_z  5-bit PLA outputs z0..z4
// Optional feature macro: CLPL_OVF_EN adds the registered signed-overflow output bus.ovf.
// WIDTH must be a nonzero multiple of 5; NSLICE = WIDTH/5 slices are processed LSB-first.

module clpl_slice_sequencer #(
    parameter int WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    clpl_slice_sequencer_if.slave   bus,
    output logic [10:0]             pla_x,
    input  logic [4:0]              pla_z
);
    localparam int NSLICE = WIDTH / 5;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef CLPL_OVF_EN
    logic             ovf_q;
`endif

    logic [IDX_W+2:0] base;
    logic [4:0]       a_sl;
    logic [4:0]       b_sl;
    logic [4:0]       g;
    logic [4:0]       p;
    logic [5:0]       c;
    logic             last_slice;

    // Bit offset of the current slice: idx * 5.
    assign base       = {3'b000, idx} * (IDX_W+3)'(5);
    assign a_sl       = a_q[base +: 5];
    assign b_sl       = b_q[base +: 5];
    assign g          = a_sl & b_sl;
    assign p          = a_sl ^ b_sl;
    assign last_slice = (idx == LAST_IDX);

    // The PLA returns its carries in a scrambled order; c[0] is the slice carry-in.
    assign c = {pla_z[3], pla_z[4], pla_z[0], pla_z[1], pla_z[2], carry_q};

    // PLA drive depends only on registers, so pla_z never reaches an output port combinationally.
    always_comb begin
        pla_x = '0;
        if (state == RUN) begin
            pla_x[0]  = carry_q;
            pla_x[2]  = g[0];
            pla_x[4]  = p[0];
            pla_x[3]  = g[1];
            pla_x[5]  = p[1];
            pla_x[1]  = g[2];
            pla_x[6]  = p[2];
            pla_x[7]  = g[3];
            pla_x[8]  = p[3];
            pla_x[10] = g[4];
            pla_x[9]  = p[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_slice)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLPL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q[base +: 5] <= p ^ c[4:0];
                    carry_q          <= c[5];
                    if (last_slice) begin
                        idx    <= '0;
                        cout_q <= c[5];
`ifdef CLPL_OVF_EN
                        // c[4] is the carry into the MSB of the whole operand.
                        ovf_q  <= c[4] ^ c[5];
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CLPL_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_clpl_slice_sequencer.sv
// tb/tb_clpl_slice_sequencer.sv - self-checking bench for clpl_slice_sequencer with a behavioural PLA

module tb_clpl_slice_sequencer;
    localparam int WIDTH  = 20;
    localparam int NSLICE = WIDTH / 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pla_x;
    logic [4:0]  pla_z;

    int n_checks = 0;
    int n_fail   = 0;

    clpl_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

    clpl_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .pla_x (pla_x),
        .pla_z (pla_z)
    );

    always #5 clk = ~clk;

    // Behavioural 5-bit carry-lookahead PLA: decode g/p from the x inputs,
    // ripple the carries, and return them in the PLA's output order.
    logic [4:0] m_g;
    logic [4:0] m_p;
    logic [5:0] m_c;
    always_comb begin
        m_g = {pla_x[10], pla_x[7], pla_x[1], pla_x[3], pla_x[2]};
        m_p = {pla_x[9],  pla_x[8], pla_x[6], pla_x[5], pla_x[4]};
        m_c = '0;
        m_c[0] = pla_x[0];
        for (int i = 0; i < 5; i++) m_c[i+1] = m_g[i] | (m_p[i] & m_c[i]);
        pla_z = {m_c[4], m_c[5], m_c[1], m_c[2], m_c[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation, follow it through RUN, hold it in DONE for `hold`
    // cycles, then drain it. x0_exp >= 0 checks the full pla_x of slice 0.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tc, input int hold, input int x0_exp);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] cvec;
        logic             exp_ovf;
        int               cyc;
        full    = {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tc);
        cvec    = ta ^ tb_v ^ full[WIDTH-1:0];
        exp_ovf = (ta[WIDTH-1] == tb_v[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);

        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);

        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.cin      = 1'($urandom);

        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            if (cyc == 0 && x0_exp >= 0) check("pla_x_slice0", 32'(pla_x), 32'(x0_exp));
            if (cyc < NSLICE) check("carry_reg", 32'(pla_x[0]), 32'(cvec[5*cyc]));
            check("in_ready_run", 32'(bus.in_ready), 32'd0);
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(NSLICE));
        check("sum", 32'(bus.sum), 32'(full[WIDTH-1:0]));
        check("cout", 32'(bus.cout), 32'(full[WIDTH]));
`ifdef CLPL_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(exp_ovf));
`endif
        check("pla_x_done", 32'(pla_x), 32'd0);

        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_sum", 32'(bus.sum), 32'(full[WIDTH-1:0]));
            check("hold_cout", 32'(bus.cout), 32'(full[WIDTH]));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_pla_x", 32'(pla_x), 32'd0);
`ifdef CLPL_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

        run_op(20'h00001, 20'h00001, 1'b0, 0, -1);
        run_op(20'hFFFFF, 20'h00000, 1'b1, 0, -1);
        run_op(20'h0001F, 20'h00001, 1'b0, 0, 32'h364);
        run_op(20'h12345, 20'h0ABCD, 1'b1, 3, -1);
        run_op(20'h7FFFF, 20'h00001, 1'b0, 0, -1);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 1, -1);
        run_op(20'h80000, 20'h80000, 1'b0, 0, -1);

        // Abort an operation just before slice 2 is processed.
        bus.a        = 20'hABCDE;
        bus.b        = 20'h13579;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_pla_x", 32'(pla_x), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) seen_valid = 1;
            tick();
        end
        check("abort_no_result", 32'(seen_valid), 32'd0);
        run_op(20'd3, 20'd4, 1'b0, 0, -1);

        for (int r = 0; r < 40; r++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
